// File: rtl/mem_access_master.sv
// mem_access_master: single-outstanding load/store initiator for a 16-bit data memory
module mem_access_master #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_sext,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_store,
    output logic        rsp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_writew,
    output logic [7:0]  mem_writeb,
    output logic [1:0]  mem_memw,
    input  logic [15:0] mem_word,
    input  logic [7:0]  mem_byte
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [16:0] LIM = 17'(DEPTH);
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic        sext_q, sext_d, store_q, store_d, err_q, err_d;
    logic        oor;
    logic [15:0] load_val;
    assign oor = {1'b0, req_addr} >= LIM;
    assign load_val = op_q[0] ? {sext_q ? {8{mem_byte[7]}} : 8'h00, mem_byte} : mem_word;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_data = data_q;
    assign rsp_store = store_q;
    assign rsp_err = err_q;
    assign mem_addr = addr_q;
    assign mem_writew = wdata_q;
    assign mem_writeb = wdata_q[7:0];
    // write strobe exists only in ACCESS for stores; rst gates it so an abort is immediate
    assign mem_memw = (state_q == ACCESS && op_q[1] && !rst) ? (op_q[0] ? 2'b01 : 2'b10) : 2'b00;
    // next-state and response capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sext_d  = sext_q;
        data_d  = data_q;
        store_d = store_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                sext_d  = req_sext;
                data_d  = 16'h0000;
                store_d = req_op[1];
                err_d   = oor;
                state_d = oor ? RESP : ACCESS;
            end
            ACCESS: begin
                data_d  = op_q[1] ? 16'h0000 : load_val;
                store_d = op_q[1];
                state_d = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // state and latched request/response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            sext_q  <= 1'b0;
            data_q  <= 16'h0000;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sext_q  <= sext_d;
            data_q  <= data_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed checks of the load/store master against a small memory model
module tb_mem_access_master;
    logic        clk = 0, rst = 0;
    logic        req_valid = 0, req_ready, req_sext = 0;
    logic [1:0]  req_op = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_store, rsp_err;
    logic [15:0] rsp_data, mem_addr, mem_writew, mem_word;
    logic [7:0]  mem_writeb, mem_byte;
    logic [1:0]  mem_memw;
    logic [15:0] mem [16];
    int errors = 0, checks = 0;

    mem_access_master #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_sext(req_sext),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_store(rsp_store), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_writew(mem_writew), .mem_writeb(mem_writeb), .mem_memw(mem_memw),
        .mem_word(mem_word), .mem_byte(mem_byte)
    );

    always #5 clk = ~clk;

    assign mem_word = mem_addr < 16 ? mem[mem_addr[3:0]] : 16'h0000;
    assign mem_byte = mem_word[7:0];

    always @(posedge clk) begin
        if (mem_addr < 16 && mem_memw == 2'b10) mem[mem_addr[3:0]] <= mem_writew;
        if (mem_addr < 16 && mem_memw == 2'b01) mem[mem_addr[3:0]][7:0] <= mem_writeb;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d, input logic s);
        req_valid = 1; req_op = op; req_addr = a; req_wdata = d; req_sext = s;
        step();
        req_valid = 0; req_op = ~op; req_addr = 16'hFFFF; req_wdata = ~d; req_sext = ~s;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_data, rsp_store, rsp_err} !== 18'h0) begin errors++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", rsp_data, rsp_store, rsp_err); end
        checks++; if ({mem_addr, mem_writew, mem_writeb, mem_memw} !== 42'h0) begin errors++; $display("FAIL reset_mem got=%h/%h/%h/%b exp=0", mem_addr, mem_writew, mem_writeb, mem_memw); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_store_word();
        accept(2'b10, 16'd3, 16'hBEEF, 1'b0);
        checks++; if (mem_memw !== 2'b10) begin errors++; $display("FAIL sw_memw got=%b exp=10", mem_memw); end
        checks++; if (mem_addr !== 16'd3 || mem_writew !== 16'hBEEF) begin errors++; $display("FAIL sw_bus got=%h/%h exp=0003/beef", mem_addr, mem_writew); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL sw_access_hs got=%b/%b exp=0/0", rsp_valid, req_ready); end
        step();
        checks++; if ({rsp_valid, rsp_store, rsp_err} !== 3'b110 || rsp_data !== 16'h0) begin errors++; $display("FAIL sw_rsp got=%b%b%b/%h exp=110/0000", rsp_valid, rsp_store, rsp_err, rsp_data); end
        checks++; if (mem_memw !== 2'b00 || mem_addr !== 16'd3) begin errors++; $display("FAIL sw_resp_mem got=%b/%h exp=00/0003", mem_memw, mem_addr); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sw_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_load_word();
        accept(2'b00, 16'd3, 16'h5555, 1'b0);
        checks++; if (mem_memw !== 2'b00) begin errors++; $display("FAIL lw_memw got=%b exp=00", mem_memw); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_store !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw_rsp got=%b/%h/%b/%b exp=1/beef/0/0", rsp_valid, rsp_data, rsp_store, rsp_err); end
        step();
    endtask

    task automatic test_load_byte();
        accept(2'b01, 16'd3, 16'h0, 1'b1);
        step();
        checks++; if (rsp_data !== 16'hFFEF) begin errors++; $display("FAIL lb_sext got=%h exp=ffef", rsp_data); end
        step();
        accept(2'b01, 16'd3, 16'h0, 1'b0);
        step();
        checks++; if (rsp_data !== 16'h00EF) begin errors++; $display("FAIL lb_zext got=%h exp=00ef", rsp_data); end
        step();
    endtask

    task automatic test_store_byte();
        accept(2'b11, 16'd15, 16'h1234, 1'b0);
        checks++; if (mem_memw !== 2'b01 || mem_writeb !== 8'h34 || mem_addr !== 16'd15) begin errors++; $display("FAIL sb_bus got=%b/%h/%h exp=01/34/000f", mem_memw, mem_writeb, mem_addr); end
        step();
        checks++; if (mem_memw !== 2'b00 || rsp_store !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL sb_rsp got=%b/%b/%b exp=00/1/1", mem_memw, rsp_store, rsp_valid); end
        step();
        accept(2'b00, 16'd15, 16'h0, 1'b0);
        step();
        checks++; if (rsp_data !== 16'h0034 || rsp_err !== 1'b0) begin errors++; $display("FAIL sb_readback got=%h/%b exp=0034/0", rsp_data, rsp_err); end
        step();
    endtask

    task automatic test_error();
        accept(2'b00, 16'd16, 16'h0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_store !== 1'b0) begin errors++; $display("FAIL err_load got=%b/%b/%h/%b exp=1/1/0000/0", rsp_valid, rsp_err, rsp_data, rsp_store); end
        checks++; if (mem_memw !== 2'b00) begin errors++; $display("FAIL err_load_memw got=%b exp=00", mem_memw); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_load_done got=%b exp=0", rsp_valid); end
        accept(2'b10, 16'hFFFF, 16'hAAAA, 1'b0);
        checks++; if (rsp_err !== 1'b1 || rsp_store !== 1'b1 || mem_memw !== 2'b00) begin errors++; $display("FAIL err_store got=%b/%b/%b exp=1/1/00", rsp_err, rsp_store, mem_memw); end
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        accept(2'b00, 16'd3, 16'h0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid; req_op = 2'b10; req_addr = 16'd4;
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || req_ready !== 1'b0 || mem_memw !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/beef/0/00", i, rsp_valid, rsp_data, req_ready, mem_memw); end
        end
        req_valid = 0;
        rsp_ready = 1;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        req_valid = 1; req_op = 2'b10; req_addr = 16'd5; req_wdata = 16'h0F0F;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_memw != 2'b00) pulses++;
        end
        req_valid = 0;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        step();
        step();
    endtask

    task automatic test_reset_mid_access();
        accept(2'b10, 16'd7, 16'h1111, 1'b0);
        checks++; if (mem_memw !== 2'b10) begin errors++; $display("FAIL rst_pre_memw got=%b exp=10", mem_memw); end
        #1 rst = 1;
        #1;
        checks++; if (mem_memw !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_abort got=%b/%b/%b exp=00/0/1", mem_memw, rsp_valid, req_ready); end
        step();
        rst = 0;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[7] !== 16'h0) begin errors++; $display("FAIL rst_after got=%b/%b/%h exp=0/1/0000", rsp_valid, req_ready, mem[7]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        test_reset();
        test_store_word();
        test_load_word();
        test_load_byte();
        test_store_byte();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
